// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam int DIGIT_W     = 4;
    localparam int ADD3_THRESH = 5;

    // Smallest digit count whose decimal range covers every BIN_WIDTH-bit value.
    function automatic int min_digits(input int bin_width);
        longint unsigned max_val;
        longint unsigned pow;
        int              d;
        max_val = (64'd1 << bin_width) - 64'd1;
        pow     = 64'd1;
        d       = 0;
        while (pow <= max_val) begin
            pow = pow * 64'd10;
            d   = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more before it is doubled.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] corrected
);

    always_comb begin
        corrected = digit;
        if (digit >= DIGIT_W'(ADD3_THRESH)) begin
            corrected = digit + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock.
// Optional leading-zero blanking output enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [BIN_WIDTH-1:0]         bin,
    output logic                         busy,
    output logic                         done,
    output logic [DIGIT_W*DIGITS-1:0]    bcd
`ifdef LEADING_ZERO_BLANK_EN
    ,
    output logic [DIGITS-1:0]            blank
`endif
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    if (DIGITS < min_digits(BIN_WIDTH)) begin : g_param_check
        $error("bcd_seq_converter: DIGITS=%0d too small for BIN_WIDTH=%0d", DIGITS, BIN_WIDTH);
    end

    state_t                 state_reg;
    logic [BCD_W-1:0]       scratch_reg;
    logic [BIN_WIDTH-1:0]   bin_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [BCD_W-1:0]       bcd_reg;
    logic                   busy_reg;
    logic                   done_reg;

    logic [BCD_W-1:0]           corrected_next;
    logic [BCD_W+BIN_WIDTH-1:0] shift_next;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
        bcd_add3 u_add3 (
            .digit     (scratch_reg[gi*DIGIT_W +: DIGIT_W]),
            .corrected (corrected_next[gi*DIGIT_W +: DIGIT_W])
        );
    end

    // Bits leaving the top of the scratch register fall off inside the shift.
    assign shift_next = {corrected_next, bin_reg} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            scratch_reg <= '0;
            bin_reg     <= '0;
            cnt_reg     <= '0;
            bcd_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        bin_reg     <= bin;
                        scratch_reg <= '0;
                        cnt_reg     <= CNT_W'(BIN_WIDTH);
                        busy_reg    <= 1'b1;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_reg <= shift_next[BCD_W+BIN_WIDTH-1:BIN_WIDTH];
                    bin_reg     <= shift_next[BIN_WIDTH-1:0];
                    cnt_reg     <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= FIN;
                    end
                end
                FIN: begin
                    bcd_reg   <= scratch_reg;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign bcd  = bcd_reg;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic [DIGITS-1:0] blank_reg;

    // Units digit never blanks so a zero result still shows one "0".
    assign blank_next[0] = 1'b0;
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
        if (gi == DIGITS - 1) begin : g_top
            assign blank_next[gi] = (scratch_reg[gi*DIGIT_W +: DIGIT_W] == '0);
        end else begin : g_mid
            assign blank_next[gi] = (scratch_reg[gi*DIGIT_W +: DIGIT_W] == '0) & blank_next[gi+1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_reg <= '0;
        end else if (state_reg == FIN) begin
            blank_reg <= blank_next;
        end
    end

    assign blank = blank_reg;
`endif

endmodule
